cw305_reg_bank_ss2: RTL and testbench

CW305_REG_BANK_SS2 -- requirements
Module: cw305_reg_bank_ss2

---
 rtl/cw305_reg_bank_ss2.sv | 249 ++++++++++++++++++++++++
 tb/tb_cw305_reg_bank_ss2.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_reg_bank_ss2.sv
// CW305 register bank: byte-addressed USB register file with a programmable
// trigger pulse generator, SS2 error counter and heartbeat LED.
module cw305_reg_bank_ss2 #(
  parameter int pBYTECNT_SIZE = 8,
  parameter int pADDR_WIDTH   = 32,
  parameter int pNUM_REGS     = 4,
  parameter int pREG_BYTES    = 4,
  parameter int pCNT_WIDTH    = 16,
  parameter int pLED_BIT      = 21
) (
  input  logic                                   usb_clk,
  input  logic                                   resetn,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  input  logic [7:0]                             write_data,
  output logic [7:0]                             read_data,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic                                   reg_addrvalid,
  input  logic                                   ss2_error,
  output logic                                   trig_out,
  output logic                                   io3,
  output logic                                   user_led
);

  localparam int AW  = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int CB  = pCNT_WIDTH / 8;
  localparam int HBW = pLED_BIT + 1;

  localparam logic [AW-1:0] A_IDENT  = AW'(32'h00);
  localparam logic [AW-1:0] A_CTRL   = AW'(32'h01);
  localparam logic [AW-1:0] A_DELAY  = AW'(32'h02);
  localparam logic [AW-1:0] A_WIDTH  = AW'(32'h03);
  localparam logic [AW-1:0] A_ERR    = AW'(32'h04);
  localparam logic [AW-1:0] A_STATUS = AW'(32'h05);
  localparam logic [AW-1:0] A_SCR    = AW'(32'h10);

  localparam logic [pCNT_WIDTH-1:0] CNT_ZERO = {pCNT_WIDTH{1'b0}};
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(32'd1);
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX  = {pCNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [pCNT_WIDTH-1:0]   cnt_r;
  logic [pCNT_WIDTH-1:0]   width_lat_r;
  logic                    trig_out_r;
  logic [pCNT_WIDTH-1:0]   trig_delay_r;
  logic [pCNT_WIDTH-1:0]   trig_width_r;
  logic                    led_en_r;
  logic                    io3_r;
  logic [pCNT_WIDTH-1:0]   err_count_r;
  logic                    err_sticky_r;
  logic                    err_prev_r;
  logic [HBW-1:0]          hb_r;
  logic                    user_led_r;
  logic [7:0]              scratch_r [pNUM_REGS][pREG_BYTES];

  logic                    wr_s;
  logic [31:0]             byte_s;
  logic [AW-1:0]           scr_off_s;
  logic                    scr_hit_s;
  logic                    ctrl_wr_s;
  logic                    go_s;
  logic                    clr_s;
  logic                    err_edge_s;
  logic                    led_en_nxt_s;
  logic [HBW-1:0]          hb_nxt_s;
  logic [pCNT_WIDTH-1:0]   err_count_nxt_s;
  logic                    err_sticky_nxt_s;
  logic [7:0]              rd_s;
  logic                    unused_s;

  assign unused_s = reg_read;

  // Selects one byte of a counter-width register; out-of-range bytes read 0.
  function automatic logic [7:0] cnt_byte(input logic [pCNT_WIDTH-1:0] v,
                                          input logic [31:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < CB; b++) begin
      r = r | ((idx == 32'(b)) ? v[b*8 +: 8] : 8'h00);
    end
    return r;
  endfunction

  // Address decode and strobes shared by write, read and control paths.
  always_comb begin
    wr_s       = reg_write & reg_addrvalid;
    byte_s     = 32'(reg_bytecnt);
    scr_off_s  = reg_address - A_SCR;
    scr_hit_s  = (reg_address >= A_SCR) && (scr_off_s < AW'(pNUM_REGS));
    ctrl_wr_s  = wr_s && (reg_address == A_CTRL) && (byte_s == 32'd0);
    go_s       = ctrl_wr_s & write_data[0];
    clr_s      = ctrl_wr_s & write_data[3];
    err_edge_s = ss2_error & ~err_prev_r;
  end

  // Next values for the error counter, LED enable and heartbeat.
  always_comb begin
    led_en_nxt_s     = ctrl_wr_s ? write_data[1] : led_en_r;
    hb_nxt_s         = hb_r + HBW'(32'd1);
    err_count_nxt_s  = err_count_r;
    err_sticky_nxt_s = err_sticky_r;
    if (clr_s) begin
      // A clear racing an error edge still records that edge.
      err_count_nxt_s  = err_edge_s ? CNT_ONE : CNT_ZERO;
      err_sticky_nxt_s = err_edge_s;
    end else if (err_edge_s) begin
      err_count_nxt_s  = (err_count_r == CNT_MAX) ? err_count_r : err_count_r + CNT_ONE;
      err_sticky_nxt_s = 1'b1;
    end else begin
      err_count_nxt_s  = err_count_r;
      err_sticky_nxt_s = err_sticky_r;
    end
  end

  // Software-writable registers: control, trigger timing and scratch bytes.
  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      led_en_r     <= 1'b0;
      io3_r        <= 1'b0;
      trig_delay_r <= CNT_ZERO;
      trig_width_r <= CNT_ZERO;
      for (int r = 0; r < pNUM_REGS; r++) begin
        for (int b = 0; b < pREG_BYTES; b++) begin
          scratch_r[r][b] <= 8'h00;
        end
      end
    end else begin
      led_en_r <= led_en_nxt_s;
      if (ctrl_wr_s) begin
        io3_r <= write_data[2];
      end
      for (int b = 0; b < CB; b++) begin
        if (wr_s && (reg_address == A_DELAY) && (byte_s == 32'(b))) begin
          trig_delay_r[b*8 +: 8] <= write_data;
        end
        if (wr_s && (reg_address == A_WIDTH) && (byte_s == 32'(b))) begin
          trig_width_r[b*8 +: 8] <= write_data;
        end
      end
      for (int r = 0; r < pNUM_REGS; r++) begin
        for (int b = 0; b < pREG_BYTES; b++) begin
          if (wr_s && scr_hit_s && (scr_off_s == AW'(r)) && (byte_s == 32'(b))) begin
            scratch_r[r][b] <= write_data;
          end
        end
      end
    end
  end

  // Error edge detection, counter, heartbeat and LED drive.
  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      err_prev_r   <= 1'b0;
      err_count_r  <= CNT_ZERO;
      err_sticky_r <= 1'b0;
      hb_r         <= {HBW{1'b0}};
      user_led_r   <= 1'b0;
    end else begin
      err_prev_r   <= ss2_error;
      err_count_r  <= err_count_nxt_s;
      err_sticky_r <= err_sticky_nxt_s;
      hb_r         <= hb_nxt_s;
      // Built from next values so the LED tracks the registers without lag.
      user_led_r   <= led_en_nxt_s ? hb_nxt_s[pLED_BIT] : err_sticky_nxt_s;
    end
  end

  // Trigger FSM; width is latched at go so mid-run writes affect the next run.
  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      width_lat_r <= CNT_ZERO;
      trig_out_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          trig_out_r <= 1'b0;
          if (go_s && (trig_width_r != CNT_ZERO)) begin
            state_r     <= ST_DELAY;
            cnt_r       <= trig_delay_r;
            width_lat_r <= trig_width_r;
          end
        end
        ST_DELAY: begin
          if (cnt_r == CNT_ZERO) begin
            state_r    <= ST_PULSE;
            cnt_r      <= width_lat_r - CNT_ONE;
            trig_out_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_r == CNT_ZERO) begin
            state_r    <= ST_IDLE;
            trig_out_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          trig_out_r <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read mux.
  always_comb begin
    rd_s = 8'h00;
    if (reg_addrvalid) begin
      case (reg_address)
        A_IDENT:  rd_s = (byte_s == 32'd0) ? 8'h5E :
                         (byte_s == 32'd1) ? 8'(pNUM_REGS) : 8'h00;
        A_CTRL:   rd_s = (byte_s == 32'd0) ? {5'b00000, io3_r, led_en_r, 1'b0} : 8'h00;
        A_DELAY:  rd_s = cnt_byte(trig_delay_r, byte_s);
        A_WIDTH:  rd_s = cnt_byte(trig_width_r, byte_s);
        A_ERR:    rd_s = cnt_byte(err_count_r, byte_s);
        A_STATUS: rd_s = (byte_s == 32'd0) ?
                         {6'b000000, err_sticky_r, (state_r != ST_IDLE)} : 8'h00;
        default: begin
          for (int r = 0; r < pNUM_REGS; r++) begin
            for (int b = 0; b < pREG_BYTES; b++) begin
              rd_s = rd_s | ((scr_hit_s && (scr_off_s == AW'(r)) && (byte_s == 32'(b))) ?
                             scratch_r[r][b] : 8'h00);
            end
          end
        end
      endcase
    end else begin
      rd_s = 8'h00;
    end
  end

  assign read_data = rd_s;
  assign trig_out  = trig_out_r;
  assign io3       = io3_r;
  assign user_led  = user_led_r;

endmodule

// File: tb/tb_cw305_reg_bank_ss2.sv
// Self-checking bench for cw305_reg_bank_ss2: directed and randomized steps
// compared against a behavioural model of the register map and trigger timing.
module tb_cw305_reg_bank_ss2;

  localparam int LEDB = 4;

  logic        usb_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] reg_address = 24'h0;
  logic [7:0]  reg_bytecnt = 8'h0;
  logic [7:0]  write_data = 8'h0;
  logic [7:0]  read_data;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic        ss2_error = 1'b0;
  logic        trig_out;
  logic        io3;
  logic        user_led;

  int total = 0;
  int bad = 0;
  logic [7:0]      scr_m [4][4];
  logic [LEDB:0]   hb_m = '0;
  logic [7:0]      rv;
  int              err_m;

  cw305_reg_bank_ss2 #(.pCNT_WIDTH(8), .pLED_BIT(LEDB)) dut (
    .usb_clk(usb_clk), .resetn(resetn), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .write_data(write_data), .read_data(read_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .ss2_error(ss2_error), .trig_out(trig_out), .io3(io3), .user_led(user_led));

  always #5 usb_clk = ~usb_clk;

  // Heartbeat model: edges since the last reset edge.
  always @(posedge usb_clk) hb_m <= resetn ? hb_m + 1'b1 : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] b, input logic [7:0] d);
    @(negedge usb_clk);
    reg_address = a; reg_bytecnt = b; write_data = d;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(posedge usb_clk); #1;
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, input logic [7:0] b, output logic [7:0] d);
    @(negedge usb_clk);
    reg_address = a; reg_bytecnt = b; reg_addrvalid = 1'b1; reg_read = 1'b1;
    #1 d = read_data;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic pulse_err(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge usb_clk) ss2_error = 1'b1;
      @(negedge usb_clk) ss2_error = 1'b0;
    end
  endtask

  // One trigger run; the pulse window is derived from delay/width arithmetic.
  task automatic run_trig(input int d, input int w, input bit inject);
    bit exp_trig, exp_busy;
    wr(24'h02, 8'd0, 8'(d));
    wr(24'h03, 8'd0, 8'(w));
    wr(24'h01, 8'd0, 8'h05);
    for (int k = 1; k <= d + w + 3; k++) begin
      @(negedge usb_clk);
      reg_addrvalid = 1'b1; reg_bytecnt = 8'd0;
      if (inject && k == 2) begin
        reg_address = 24'h01; write_data = 8'h05; reg_write = 1'b1;
      end else if (inject && k == 3) begin
        reg_address = 24'h02; write_data = 8'(d + 2); reg_write = 1'b1;
      end else begin
        reg_write = 1'b0;
      end
      @(posedge usb_clk); #1;
      reg_write = 1'b0; reg_address = 24'h05;
      #1;
      exp_trig = (w != 0) && (k >= d + 1) && (k <= d + w);
      exp_busy = (w != 0) && (k <= d + w);
      chk($sformatf("trig d=%0d w=%0d k=%0d", d, w, k), 32'(trig_out), 32'(exp_trig));
      chk($sformatf("busy d=%0d w=%0d k=%0d", d, w, k), 32'(read_data[0]), 32'(exp_busy));
    end
    reg_addrvalid = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 4; r++) for (int b = 0; b < 4; b++) scr_m[r][b] = 8'h00;

    // Reset state
    repeat (3) @(posedge usb_clk);
    #1;
    chk("rst trig_out", 32'(trig_out), 32'd0);
    chk("rst io3", 32'(io3), 32'd0);
    chk("rst user_led", 32'(user_led), 32'd0);
    @(negedge usb_clk) resetn = 1'b1;

    // Identity and scratch basics
    rd(24'h00, 8'd0, rv); chk("ident b0", 32'(rv), 32'h5E);
    rd(24'h00, 8'd1, rv); chk("ident b1", 32'(rv), 32'h04);
    rd(24'h00, 8'd2, rv); chk("ident b2", 32'(rv), 32'h00);
    wr(24'h10, 8'd3, 8'hA5); scr_m[0][3] = 8'hA5;
    for (int b = 0; b < 5; b++) begin
      rd(24'h10, 8'(b), rv);
      chk($sformatf("scr0 b%0d", b), 32'(rv), 32'((b == 3) ? 8'hA5 : 8'h00));
    end

    // Random scratch traffic including unmapped registers and bytes
    for (int i = 0; i < 40; i++) begin
      int a, b;
      logic [7:0] d;
      a = 16 + int'($urandom_range(0, 5));
      b = int'($urandom_range(0, 5));
      d = 8'($urandom);
      wr(24'(a), 8'(b), d);
      if (a < 20 && b < 4) scr_m[a - 16][b] = d;
    end
    for (int a = 16; a < 22; a++) begin
      for (int b = 0; b < 6; b++) begin
        rd(24'(a), 8'(b), rv);
        chk($sformatf("scr a=%0h b=%0d", a, b), 32'(rv),
            32'((a < 20 && b < 4) ? scr_m[a - 16][b] : 8'h00));
      end
    end
    wr(24'h00, 8'd0, 8'h11); rd(24'h00, 8'd0, rv); chk("ident ro", 32'(rv), 32'h5E);
    wr(24'h20, 8'd0, 8'h77); rd(24'h20, 8'd0, rv); chk("unmapped", 32'(rv), 32'h00);
    reg_address = 24'h10; reg_bytecnt = 8'd3; reg_addrvalid = 1'b0;
    #1 chk("addrvalid low", 32'(read_data), 32'h00);

    // CTRL read-back, io3, go with zero width
    wr(24'h01, 8'd0, 8'h0F);
    rd(24'h01, 8'd0, rv); chk("ctrl rb", 32'(rv), 32'h06);
    chk("io3 set", 32'(io3), 32'd1);
    wr(24'h01, 8'd0, 8'h04);
    run_trig(4, 0, 1'b0);

    // Directed trigger with mid-run go and delay rewrite, then random runs
    run_trig(3, 2, 1'b1);
    for (int i = 0; i < 6; i++) run_trig(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 1'b0);

    // Error counter: random count, clear, saturation, clear racing an edge
    err_m = int'($urandom_range(5, 40));
    pulse_err(err_m);
    rd(24'h04, 8'd0, rv); chk("err rand", 32'(rv), 32'(err_m));
    rd(24'h05, 8'd0, rv); chk("sticky rand", 32'(rv[1]), 32'd1);
    chk("led sticky", 32'(user_led), 32'd1);
    wr(24'h01, 8'd0, 8'h0C);
    rd(24'h04, 8'd0, rv); chk("err clr", 32'(rv), 32'd0);
    rd(24'h05, 8'd0, rv); chk("sticky clr", 32'(rv[1]), 32'd0);
    chk("led clr", 32'(user_led), 32'd0);
    pulse_err(300);
    rd(24'h04, 8'd0, rv); chk("err sat", 32'(rv), 32'hFF);
    rd(24'h04, 8'd1, rv); chk("err b1", 32'(rv), 32'h00);
    rd(24'h05, 8'd0, rv); chk("sticky sat", 32'(rv[1]), 32'd1);
    chk("led sat", 32'(user_led), 32'd1);
    @(negedge usb_clk);
    ss2_error = 1'b1;
    reg_address = 24'h01; reg_bytecnt = 8'd0; write_data = 8'h0C;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(posedge usb_clk); #1;
    reg_write = 1'b0; reg_addrvalid = 1'b0;
    @(negedge usb_clk) ss2_error = 1'b0;
    rd(24'h04, 8'd0, rv); chk("err clr+edge", 32'(rv), 32'd1);
    rd(24'h05, 8'd0, rv); chk("sticky clr+edge", 32'(rv[1]), 32'd1);

    // Heartbeat on LED
    wr(24'h01, 8'd0, 8'h06);
    for (int i = 0; i < 40; i++) begin
      @(posedge usb_clk); #1;
      chk($sformatf("hb led %0d", i), 32'(user_led), 32'(hb_m[LEDB]));
    end
    wr(24'h01, 8'd0, 8'h04);

    // Reset during PULSE
    wr(24'h02, 8'd0, 8'd2);
    wr(24'h03, 8'd0, 8'd5);
    wr(24'h01, 8'd0, 8'h05);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(posedge usb_clk); #1;
        seen = trig_out;
      end
      chk("pulse seen", 32'(seen), 32'd1);
    end
    @(negedge usb_clk) resetn = 1'b0;
    @(posedge usb_clk); #1;
    chk("rst pulse trig", 32'(trig_out), 32'd0);
    chk("rst pulse io3", 32'(io3), 32'd0);
    chk("rst pulse led", 32'(user_led), 32'd0);
    rd(24'h00, 8'd0, rv); chk("rst ident", 32'(rv), 32'h5E);
    for (int a = 1; a < 6; a++) begin
      rd(24'(a), 8'd0, rv); chk($sformatf("rst reg %0d", a), 32'(rv), 32'h00);
    end
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        rd(24'(16 + r), 8'(b), rv); chk($sformatf("rst scr %0d.%0d", r, b), 32'(rv), 32'h00);
      end
    end
    @(negedge usb_clk) resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge usb_clk); #1;
      chk($sformatf("no pulse after rst %0d", i), 32'(trig_out), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
